// File: rtl/nsquare_sum_pkg.sv
// Shared types and default sizing for the sum-of-squares engine.
package nsquare_sum_pkg;

    localparam int N_WIDTH_DEF   = 3;
    localparam int SUM_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nsquare_sum_if.sv
// Host-side request/result bus of the sum-of-squares engine.
// sum_ovf only exists when NSQ_SATURATE_EN is defined.
interface nsquare_sum_if #(
    parameter int N_WIDTH   = 3,
    parameter int SUM_WIDTH = 8
);
    logic [N_WIDTH-1:0]   N;
    logic                 N_valid;
    logic                 ack;
    logic [SUM_WIDTH-1:0] sum_out;
    logic                 sum_valid;
`ifdef NSQ_SATURATE_EN
    logic                 sum_ovf;
`endif

    modport master (
        output N, N_valid, ack,
        input  sum_out, sum_valid
`ifdef NSQ_SATURATE_EN
        , input sum_ovf
`endif
    );

    modport slave (
        input  N, N_valid, ack,
        output sum_out, sum_valid
`ifdef NSQ_SATURATE_EN
        , output sum_ovf
`endif
    );

endinterface

// File: rtl/nsquare_sum_sq.sv
// Combinational squarer: idx -> idx*idx at full 2*N_WIDTH precision.
module nsquare_sum_sq
    import nsquare_sum_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF
) (
    input  logic [N_WIDTH-1:0]   idx,
    output logic [2*N_WIDTH-1:0] sq
);

    // Operands widened first so the product never truncates.
    assign sq = {{N_WIDTH{1'b0}}, idx} * {{N_WIDTH{1'b0}}, idx};

endmodule

// File: rtl/nsquare_sum.sv
// Iterative sum-of-squares engine: S = 1^2 + ... + N^2 with valid/ack result hold.
// The square of idx is registered (sq_q) before it is accumulated, so the
// sequence runs k steps of squaring plus one drain step plus the output step:
// sum_valid rises k+2 edges after capture.
// Optional: NSQ_SATURATE_EN makes the accumulator saturate and adds a sticky sum_ovf.
module nsquare_sum
    import nsquare_sum_pkg::*;
#(
    parameter int N_WIDTH   = N_WIDTH_DEF,
    parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    nsquare_sum_if.slave bus
);

    state_e               state_q, state_d;
    logic [N_WIDTH-1:0]   idx_q, idx_d;
    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic [SUM_WIDTH-1:0] sq_q, sq_d;
    logic                 drain_q, drain_d;
    logic [SUM_WIDTH-1:0] sum_out_q, sum_out_d;
    logic                 sum_valid_q, sum_valid_d;
`ifdef NSQ_SATURATE_EN
    logic                 ovf_q, ovf_d;
`endif

    logic [2*N_WIDTH-1:0] sq_w;
    logic [SUM_WIDTH:0]   add_w;

    nsquare_sum_sq #(.N_WIDTH(N_WIDTH)) u_sq (
        .idx (idx_q),
        .sq  (sq_w)
    );

    // One extra bit keeps the carry for saturation detection.
    assign add_w = {1'b0, acc_q} + {1'b0, sq_q};

    // State and datapath registers; reset clears everything including outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            sq_q        <= '0;
            drain_q     <= 1'b0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
`ifdef NSQ_SATURATE_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            sq_q        <= sq_d;
            drain_q     <= drain_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
`ifdef NSQ_SATURATE_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update for capture, iteration and hand-off.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sq_d        = sq_q;
        drain_d     = drain_q;
        sum_out_d   = sum_out_q;
        sum_valid_d = sum_valid_q;
`ifdef NSQ_SATURATE_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.N_valid) begin
                    idx_d   = bus.N;
                    acc_d   = '0;
                    sq_d    = '0;
                    drain_d = 1'b0;
`ifdef NSQ_SATURATE_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef NSQ_SATURATE_EN
                if (add_w[SUM_WIDTH]) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = add_w[SUM_WIDTH-1:0];
                end
`else
                acc_d = add_w[SUM_WIDTH-1:0];
`endif
                if (idx_q != '0) begin
                    sq_d  = SUM_WIDTH'(sq_w);
                    idx_d = idx_q - N_WIDTH'(1);
                end else begin
                    sq_d = '0;
                    // First idx==0 edge absorbs the last pending square.
                    if (drain_q) begin
                        sum_out_d   = acc_q;
                        sum_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        drain_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.ack) begin
                    sum_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sum_out   = sum_out_q;
    assign bus.sum_valid = sum_valid_q;
`ifdef NSQ_SATURATE_EN
    assign bus.sum_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nsquare_sum.sv
// Directed self-checking bench for nsquare_sum (default N_WIDTH=3, SUM_WIDTH=8).
module tb_nsquare_sum;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nsquare_sum_if #(.N_WIDTH(3), .SUM_WIDTH(8)) bus ();

    nsquare_sum #(.N_WIDTH(3), .SUM_WIDTH(8)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle request; returns #1 after the capture edge.
    task automatic request(input logic [2:0] n);
        bus.N       = n;
        bus.N_valid = 1'b1;
        step();
        bus.N_valid = 1'b0;
    endtask

    // Edges until sum_valid is seen (-1 if not within the budget).
    task automatic wait_valid(output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = -1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step();
            if (bus.sum_valid === 1'b1) begin
                cnt  = i;
                seen = 1'b1;
            end
        end
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.N = 3'd0; bus.N_valid = 1'b0; bus.ack = 1'b0;
        #12;
        checks++;
        if (bus.sum_out !== 8'd0) begin
            errors++; $display("FAIL reset_sum_out got %0d want 0", bus.sum_out);
        end
        checks++;
        if (bus.sum_valid !== 1'b0) begin
            errors++; $display("FAIL reset_sum_valid got %b want 0", bus.sum_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int cnt;
        request(3'd4);
        wait_valid(cnt);
        checks++;
        if (cnt !== 6) begin
            errors++; $display("FAIL n4_latency got %0d want 6", cnt);
        end
        checks++;
        if (bus.sum_out !== 8'd30) begin
            errors++; $display("FAIL n4_sum got %0d want 30", bus.sum_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.sum_valid !== 1'b1 || bus.sum_out !== 8'd30) begin
                errors++; $display("FAIL n4_hold cyc %0d got v=%b s=%0d want v=1 s=30", i, bus.sum_valid, bus.sum_out);
            end
        end
        do_ack();
        checks++;
        if (bus.sum_valid !== 1'b0 || bus.sum_out !== 8'd30) begin
            errors++; $display("FAIL n4_ack got v=%b s=%0d want v=0 s=30", bus.sum_valid, bus.sum_out);
        end
    endtask

    task automatic test_ack();
        int cnt;
        request(3'd3);
        wait_valid(cnt);
        checks++;
        if (cnt !== 5 || bus.sum_out !== 8'd14) begin
            errors++; $display("FAIL n3_result got cnt=%0d s=%0d want cnt=5 s=14", cnt, bus.sum_out);
        end
        do_ack();
        checks++;
        if (bus.sum_valid !== 1'b0) begin
            errors++; $display("FAIL n3_ack_drop got %b want 0", bus.sum_valid);
        end
    endtask

    task automatic test_bounds();
        int cnt;
        request(3'd0);
        wait_valid(cnt);
        checks++;
        if (cnt !== 2 || bus.sum_out !== 8'd0) begin
            errors++; $display("FAIL n0_result got cnt=%0d s=%0d want cnt=2 s=0", cnt, bus.sum_out);
        end
        do_ack();
        request(3'd7);
        wait_valid(cnt);
        checks++;
        if (cnt !== 9 || bus.sum_out !== 8'd140) begin
            errors++; $display("FAIL n7_result got cnt=%0d s=%0d want cnt=9 s=140", cnt, bus.sum_out);
        end
`ifdef NSQ_SATURATE_EN
        checks++;
        if (bus.sum_ovf !== 1'b0) begin
            errors++; $display("FAIL n7_ovf got %b want 0", bus.sum_ovf);
        end
`endif
        do_ack();
    endtask

    task automatic test_ignore_req();
        int cnt;
        request(3'd2);
        bus.N       = 3'd5;
        bus.N_valid = 1'b1;
        step();
        bus.N_valid = 1'b0;
        wait_valid(cnt);
        checks++;
        if (cnt !== 3 || bus.sum_out !== 8'd5) begin
            errors++; $display("FAIL calc_ignore got cnt=%0d s=%0d want cnt=3 s=5", cnt, bus.sum_out);
        end
        do_ack();
        step(); step();
        checks++;
        if (bus.sum_valid !== 1'b0) begin
            errors++; $display("FAIL calc_ignore_idle got %b want 0", bus.sum_valid);
        end
    endtask

    task automatic test_async_reset();
        int cnt;
        // Leave a nonzero sum_out behind so the clear is observable.
        request(3'd3);
        wait_valid(cnt);
        do_ack();
        request(3'd7);
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.sum_valid !== 1'b0 || bus.sum_out !== 8'd0) begin
            errors++; $display("FAIL rst_mid_calc got v=%b s=%0d want v=0 s=0", bus.sum_valid, bus.sum_out);
        end
        step();
        rst = 1'b0;
        request(3'd1);
        wait_valid(cnt);
        checks++;
        if (cnt !== 3 || bus.sum_out !== 8'd1) begin
            errors++; $display("FAIL n1_result got cnt=%0d s=%0d want cnt=3 s=1", cnt, bus.sum_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.sum_valid !== 1'b0 || bus.sum_out !== 8'd0) begin
            errors++; $display("FAIL rst_mid_done got v=%b s=%0d want v=0 s=0", bus.sum_valid, bus.sum_out);
        end
        step();
        rst = 1'b0;
        request(3'd2);
        wait_valid(cnt);
        checks++;
        if (cnt !== 4 || bus.sum_out !== 8'd5) begin
            errors++; $display("FAIL post_rst_n2 got cnt=%0d s=%0d want cnt=4 s=5", cnt, bus.sum_out);
        end
        do_ack();
    endtask

    task automatic test_ack_no_effect();
        int cnt;
        int cnt2;
        bus.ack = 1'b1;
        step(); step();
        checks++;
        if (bus.sum_valid !== 1'b0) begin
            errors++; $display("FAIL ack_idle got %b want 0", bus.sum_valid);
        end
        bus.ack = 1'b0;
        request(3'd3);
        bus.ack = 1'b1;
        step(); step();
        bus.ack = 1'b0;
        wait_valid(cnt);
        checks++;
        if (cnt !== 3 || bus.sum_out !== 8'd14) begin
            errors++; $display("FAIL ack_calc got cnt=%0d s=%0d want cnt=3 s=14", cnt, bus.sum_out);
        end
        // ack and request on the same edge: only the ack is taken.
        bus.ack     = 1'b1;
        bus.N       = 3'd2;
        bus.N_valid = 1'b1;
        step();
        bus.ack = 1'b0;
        checks++;
        if (bus.sum_valid !== 1'b0 || bus.sum_out !== 8'd14) begin
            errors++; $display("FAIL ack_req_edge got v=%b s=%0d want v=0 s=14", bus.sum_valid, bus.sum_out);
        end
        step();
        bus.N_valid = 1'b0;
        wait_valid(cnt2);
        checks++;
        if (cnt2 !== 4 || bus.sum_out !== 8'd5) begin
            errors++; $display("FAIL ack_req_capture got cnt=%0d s=%0d want cnt=4 s=5", cnt2, bus.sum_out);
        end
        do_ack();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_ack();
        test_bounds();
        test_ignore_req();
        test_async_reset();
        test_ack_no_effect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
